// File: rtl/fetchflare_stride_engine.sv
// Strided prefetch request generator: issues nreq addresses base + i*stride,
// bounds outstanding requests to MAX_INFLIGHT and waits for all responses.
module fetchflare_stride_engine #(
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned TID_WIDTH    = 6,
  parameter int unsigned ENGINE_ID    = 0,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [ADDR_WIDTH-1:0] cfg_base_i,
  input  logic [ADDR_WIDTH-1:0] cfg_stride_i,
  input  logic [CNT_WIDTH-1:0]  cfg_nreq_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [ADDR_WIDTH-1:0] req_addr_o,
  output logic [TID_WIDTH-1:0]  req_tid_o,
  input  logic                  rsp_valid_i,
  input  logic [TID_WIDTH-1:0]  rsp_tid_i,
  input  logic                  rsp_error_i
);

  localparam int unsigned          IW     = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IW-1:0]        MAX_IF = IW'(MAX_INFLIGHT);
  localparam logic [TID_WIDTH-1:0] OWN_ID = TID_WIDTH'(ENGINE_ID);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [IW-1:0]         inflight_q, inflight_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  cfg_hs, req_hs, rsp_acc;

  assign cfg_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign error_o     = error_q;
  // inflight only grows on a handshake, so valid stays stable until accepted
  assign req_valid_o = (state_q == ISSUE) && (inflight_q < MAX_IF);
  assign req_addr_o  = addr_q;
  assign req_tid_o   = OWN_ID;

  assign cfg_hs  = cfg_valid_i && cfg_ready_o;
  assign req_hs  = req_valid_o && req_ready_i;
  assign rsp_acc = rsp_valid_i && (rsp_tid_i == OWN_ID) && (inflight_q != '0);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    remaining_d = remaining_q;
    inflight_d  = inflight_q;
    done_d      = 1'b0;
    error_d     = error_q;

    if (req_hs && !rsp_acc) begin
      inflight_d = inflight_q + IW'(1);
    end else if (!req_hs && rsp_acc) begin
      inflight_d = inflight_q - IW'(1);
    end

    if (rsp_acc && rsp_error_i) begin
      error_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (cfg_hs) begin
          error_d = 1'b0;
          if (cfg_nreq_i == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = cfg_base_i;
            stride_d    = cfg_stride_i;
            remaining_d = cfg_nreq_i;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (req_hs) begin
          addr_d      = addr_q + stride_q;
          remaining_d = remaining_q - CNT_WIDTH'(1);
        end
        if (req_hs && (remaining_q == CNT_WIDTH'(1))) begin
          state_d = DRAIN;
        end else if (abort_i) begin
          remaining_d = '0;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (inflight_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      remaining_q <= '0;
      inflight_q  <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_fetchflare_stride_engine.sv
// Bench for fetchflare_stride_engine: directed scenarios plus randomized jobs
// checked against a transaction-level model of the job protocol.
module tb_fetchflare_stride_engine;

  localparam int unsigned AW   = 64;
  localparam int unsigned CW   = 16;
  localparam int unsigned TW   = 6;
  localparam int unsigned ID   = 5;
  localparam int unsigned MAXI = 4;
  localparam logic [TW-1:0] OWN = TW'(ID);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid, cfg_ready;
  logic [AW-1:0] cfg_base, cfg_stride;
  logic [CW-1:0] cfg_nreq;
  logic          abort, busy, done, error;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic [TW-1:0] req_tid;
  logic          rsp_valid, rsp_error;
  logic [TW-1:0] rsp_tid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetchflare_stride_engine #(
    .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .TID_WIDTH(TW),
    .ENGINE_ID(ID), .MAX_INFLIGHT(MAXI)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_base_i(cfg_base), .cfg_stride_i(cfg_stride), .cfg_nreq_i(cfg_nreq),
    .abort_i(abort), .busy_o(busy), .done_o(done), .error_o(error),
    .req_valid_o(req_valid), .req_ready_i(req_ready),
    .req_addr_o(req_addr), .req_tid_o(req_tid),
    .rsp_valid_i(rsp_valid), .rsp_tid_i(rsp_tid), .rsp_error_i(rsp_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input int nreq);
    cfg_valid  = 1'b1;
    cfg_base   = base;
    cfg_stride = stride;
    cfg_nreq   = CW'(nreq);
    tick();
    cfg_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_valid = 0; cfg_base = '0; cfg_stride = '0; cfg_nreq = '0; abort = 0;
    req_ready = 0; rsp_valid = 0; rsp_tid = '0; rsp_error = 0;
    tick(); tick();
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (error !== 1'b0)     begin bad++; $display("FAIL reset_error: got %b want 0", error); end
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", req_valid); end
    total++; if (req_addr !== '0)    begin bad++; $display("FAIL reset_addr: got %0h want 0", req_addr); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  // Ready held high, each response returned two cycles after its request.
  task automatic test_stream(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                             input logic [AW-1:0] e0, input logic [AW-1:0] e1,
                             input logic [AW-1:0] e2);
    logic [AW-1:0] exp_addr [3];
    int issue_edge[$];
    int n = 0, dones = 0, done_c = -1, last_issue_c = -1;
    exp_addr[0] = e0; exp_addr[1] = e1; exp_addr[2] = e2;
    req_ready = 1'b1;
    start_job(base, stride, 3);
    for (int c = 0; c < 12; c++) begin
      if (done === 1'b1) begin dones++; done_c = c; end
      if (req_valid === 1'b1) begin
        total++;
        if (n >= 3) begin
          bad++; $display("FAIL stream_extra_req: got request %0d want 3 total", n + 1);
        end else if (req_addr !== exp_addr[n]) begin
          bad++; $display("FAIL stream_addr%0d: got %0h want %0h", n, req_addr, exp_addr[n]);
        end
        total++; if (req_tid !== OWN) begin bad++; $display("FAIL stream_tid: got %0d want %0d", req_tid, OWN); end
        issue_edge.push_back(c + 1);
        last_issue_c = c;
        n++;
      end
      rsp_valid = 1'b0;
      if (issue_edge.size() > 0 && issue_edge[0] + 2 == c + 1) begin
        rsp_valid = 1'b1; rsp_tid = OWN; rsp_error = 1'b0;
        void'(issue_edge.pop_front());
      end
      tick();
    end
    rsp_valid = 1'b0; req_ready = 1'b0;
    total++; if (n !== 3)            begin bad++; $display("FAIL stream_count: got %0d want 3", n); end
    total++; if (last_issue_c !== 2) begin bad++; $display("FAIL stream_consecutive: got last at %0d want 2", last_issue_c); end
    total++; if (dones !== 1)        begin bad++; $display("FAIL stream_done_pulses: got %0d want 1", dones); end
    total++; if (done_c !== 5)       begin bad++; $display("FAIL stream_done_time: got %0d want 5", done_c); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL stream_idle: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int cnt = 0;
    req_ready = 1'b1;
    start_job(64'h2000, 64'd8, 8);
    for (int c = 0; c < 10; c++) begin
      if (req_valid === 1'b1) cnt++;
      tick();
    end
    total++; if (cnt !== 4)          begin bad++; $display("FAIL bp_first_burst: got %0d want 4", cnt); end
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_low: got %b want 0", req_valid); end
    rsp_valid = 1'b1; rsp_tid = OWN ^ TW'(3); rsp_error = 1'b0;
    tick();
    rsp_valid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (req_valid === 1'b1) cnt++;
      tick();
    end
    total++; if (cnt !== 0) begin bad++; $display("FAIL bp_foreign_tid: got %0d issues want 0", cnt); end
    rsp_valid = 1'b1; rsp_tid = OWN;
    tick();
    rsp_valid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (req_valid === 1'b1) cnt++;
      tick();
    end
    total++; if (cnt !== 1) begin bad++; $display("FAIL bp_one_more: got %0d want 1", cnt); end
    for (int c = 0; c < 100 && busy === 1'b1; c++) begin
      rsp_valid = 1'b1; rsp_tid = OWN;
      tick();
    end
    rsp_valid = 1'b0; req_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_drain_timeout: got busy %b want 0", busy); end
  endtask

  task automatic test_abort();
    int cnt = 0;
    req_ready = 1'b1;
    start_job(64'h8000, 64'h100, 5);
    tick(); tick();
    req_ready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL abort_valid_drop: got %b want 0", req_valid); end
    total++; if (busy !== 1'b1)      begin bad++; $display("FAIL abort_drain_busy: got %b want 1", busy); end
    req_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (req_valid === 1'b1) cnt++;
      tick();
    end
    total++; if (cnt !== 0) begin bad++; $display("FAIL abort_no_issue: got %0d want 0", cnt); end
    rsp_valid = 1'b1; rsp_tid = OWN; rsp_error = 1'b0;
    tick();
    total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL abort_first_rsp: got done=%b busy=%b want 0 1", done, busy); end
    tick();
    rsp_valid = 1'b0;
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL abort_done: got done=%b busy=%b want 1 0", done, busy); end
    tick();
    req_ready = 1'b0;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_zero_and_error();
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL zero_cfg_ready: got %b want 1", cfg_ready); end
    start_job(64'h1234, 64'h10, 0);
    total++; if (done !== 1'b1 || busy !== 1'b0 || req_valid !== 1'b0)
      begin bad++; $display("FAIL zero_done: got done=%b busy=%b valid=%b want 1 0 0", done, busy, req_valid); end
    tick();
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL zero_after: got done=%b busy=%b want 0 0", done, busy); end
    req_ready = 1'b1;
    start_job(64'h4000, 64'h40, 1);
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1; rsp_tid = OWN ^ TW'(1); rsp_error = 1'b1;
    tick();
    total++; if (error !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL err_foreign: got err=%b busy=%b want 0 1", error, busy); end
    rsp_tid = OWN;
    tick();
    rsp_valid = 1'b0; rsp_error = 1'b0;
    total++; if (error !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL err_set: got err=%b done=%b want 1 1", error, done); end
    tick(); tick();
    total++; if (error !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", error); end
    start_job(64'h0, 64'h0, 0);
    total++; if (error !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", error); end
    rsp_valid = 1'b1; rsp_tid = OWN; rsp_error = 1'b1;
    tick();
    rsp_valid = 1'b0; rsp_error = 1'b0;
    total++; if (error !== 1'b0) begin bad++; $display("FAIL err_idle_rsp: got %b want 0", error); end
  endtask

  task automatic test_reset_midjob();
    req_ready = 1'b1;
    start_job(64'hA000, 64'h20, 6);
    tick(); tick();
    req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || req_valid !== 1'b0 ||
                 req_addr !== '0 || cfg_ready !== 1'b1)
      begin bad++; $display("FAIL midjob_reset: got busy=%b done=%b err=%b valid=%b addr=%0h rdy=%b want 0 0 0 0 0 1",
                            busy, done, error, req_valid, req_addr, cfg_ready); end
    #1 rst_n = 1'b1;
    tick();
    rsp_valid = 1'b1; rsp_tid = OWN; rsp_error = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || req_valid !== 1'b0)
        begin bad++; $display("FAIL stale_rsp%0d: got busy=%b done=%b err=%b valid=%b want 0 0 0 0", c, busy, done, error, req_valid); end
    end
    rsp_valid = 1'b0; rsp_error = 1'b0;
  endtask

  // Model: requests are base + k*stride; at most MAXI unanswered; job ends
  // one cycle after the last outstanding response once issuing has stopped.
  task automatic test_random_jobs();
    for (int j = 0; j < 40; j++) begin
      logic [AW-1:0] base, stride;
      longint sv;
      int nreq, issued, outst, phase, guard;
      bit exp_done, exp_err, exp_valid, hs, acc;
      base = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        sv = longint'($urandom_range(0, 511)) - 256;
        stride = AW'(sv);
      end else begin
        stride = {$urandom, $urandom};
      end
      nreq = (j % 7 == 0) ? 0 : int'($urandom_range(1, 12));
      start_job(base, stride, nreq);
      phase = (nreq > 0) ? 1 : 0;
      issued = 0; outst = 0; exp_done = (nreq == 0); exp_err = 1'b0; guard = 0;
      forever begin
        exp_valid = (phase == 1) && (outst < int'(MAXI));
        total++; if (busy !== (phase != 0)) begin bad++; $display("FAIL rnd_busy j%0d: got %b want %b", j, busy, phase != 0); end
        total++; if (req_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid j%0d: got %b want %b", j, req_valid, exp_valid); end
        if (exp_valid) begin
          total++; if (req_addr !== base + stride * AW'(issued))
            begin bad++; $display("FAIL rnd_addr j%0d: got %0h want %0h", j, req_addr, base + stride * AW'(issued)); end
          total++; if (req_tid !== OWN) begin bad++; $display("FAIL rnd_tid j%0d: got %0d want %0d", j, req_tid, OWN); end
        end
        total++; if (done !== exp_done) begin bad++; $display("FAIL rnd_done j%0d: got %b want %b", j, done, exp_done); end
        total++; if (error !== exp_err) begin bad++; $display("FAIL rnd_error j%0d: got %b want %b", j, error, exp_err); end
        if (phase == 0 && !exp_done) break;
        if (guard > 500) begin
          bad++; $display("FAIL rnd_timeout j%0d: got no completion want done within 500 cycles", j);
          break;
        end
        req_ready = ($urandom_range(0, 3) != 0);
        abort     = ($urandom_range(0, 15) == 0);
        rsp_error = ($urandom_range(0, 7) == 0);
        case ($urandom_range(0, 3))
          0, 1: begin rsp_valid = 1'b1; rsp_tid = OWN; end
          2:    begin rsp_valid = 1'b1; rsp_tid = OWN ^ TW'($urandom_range(1, 63)); end
          default: rsp_valid = 1'b0;
        endcase
        hs  = exp_valid && req_ready;
        acc = rsp_valid && (rsp_tid == OWN) && (outst > 0);
        if (acc && rsp_error) exp_err = 1'b1;
        outst = outst + int'(hs) - int'(acc);
        exp_done = 1'b0;
        if (phase == 1) begin
          if (hs) issued++;
          if ((hs && issued == nreq) || abort) phase = 2;
        end else if (phase == 2 && outst == 0) begin
          phase = 0;
          exp_done = 1'b1;
        end
        tick();
        guard++;
      end
      rsp_valid = 1'b0; abort = 1'b0; req_ready = 1'b0; rsp_error = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_stream(64'h1000, 64'd64, 64'h1000, 64'h1040, 64'h1080);
    test_stream(64'h40, 64'hFFFF_FFFF_FFFF_FFC0, 64'h40, 64'h0, 64'hFFFF_FFFF_FFFF_FFC0);
    test_backpressure();
    test_abort();
    test_zero_and_error();
    test_reset_midjob();
    test_random_jobs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
